booth_pp_accum: RTL and testbench

//  Consumer side of the radix-8 Booth digit code (sign-magnitude sel[3:0], magnitudes 0..4).

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_pp_gen.sv | 34 +++
 rtl/booth_pp_accum.sv | 149 ++++++++++++++
 tb/tb_booth_pp_accum.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-8 Booth digit consumer: sel field layout,
// magnitude encodings, illegal-code check and FSM state encoding.
package booth_pkg;

  localparam int SEL_W        = 4;
  localparam int SEL_SIGN_BIT = 3;
  localparam int SEL_MAG_MSB  = 2;
  localparam int SEL_MAG_LSB  = 0;

  localparam logic [2:0] MAG_0 = 3'd0;
  localparam logic [2:0] MAG_1 = 3'd1;
  localparam logic [2:0] MAG_2 = 3'd2;
  localparam logic [2:0] MAG_3 = 3'd3;
  localparam logic [2:0] MAG_4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitudes above 4 and "negative zero" are never produced by the encoder.
  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    logic [2:0] mag;
    mag = sel[SEL_MAG_MSB:SEL_MAG_LSB];
    return (mag > MAG_4) || (sel[SEL_SIGN_BIT] && (mag == MAG_0));
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth digit decoder: selects 0/a/2a/3a/4a from a digit code and
// reports its sign and whether the code is illegal (illegal codes decode to zero).
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int A_W = 8
) (
  input  logic [A_W-1:0]        a,
  input  logic [A_W+1:0]        m3,
  input  logic [SEL_W-1:0]      sel,
  output logic signed [A_W+2:0] pp_mag,
  output logic                  pp_neg,
  output logic                  illegal
);

  logic [A_W+1:0] mag;

  always_comb begin
    mag = '0;
    case (sel[SEL_MAG_MSB:SEL_MAG_LSB])
      MAG_0:   mag = '0;
      MAG_1:   mag = {2'b00, a};
      MAG_2:   mag = {1'b0, a, 1'b0};
      MAG_3:   mag = m3;
      MAG_4:   mag = {a, 2'b00};
      default: mag = '0;
    endcase
    illegal = sel_illegal(sel);
    if (illegal) mag = '0;
    pp_neg = sel[SEL_SIGN_BIT] & ~illegal;
    pp_mag = signed'({1'b0, mag});
  end

endmodule

// File: rtl/booth_pp_accum.sv
// Radix-8 Booth partial-product accumulator: latches a pixel, sums NDIG signed digit
// terms into a signed product. Define BOOTH_ACC_SAT_EN to clamp the result to pixel range.
module booth_pp_accum
  import booth_pkg::*;
#(
  parameter  int A_W  = 8,
  parameter  int NDIG = 3,
  localparam int P_W  = A_W + 3*NDIG + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [A_W-1:0]        a_in,
  input  logic                  dig_valid,
  output logic                  dig_ready,
  input  logic [SEL_W-1:0]      dig_sel,
  output logic                  prod_valid,
  input  logic                  prod_ready,
  output logic signed [P_W-1:0] prod,
  output logic                  prod_err,
  output logic                  prod_sat
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MAG_W = A_W + 3;

  state_t state, state_nxt;

  logic [A_W-1:0]          a_r;
  logic [A_W+1:0]          m3_r;
  logic signed [P_W-1:0]   acc;
  logic [IDX_W-1:0]        idx;
  logic                    err_r;

  logic signed [MAG_W-1:0] pp_mag;
  logic                    pp_neg;
  logic                    pp_ill;
  logic signed [P_W-1:0]   mag_ext;
  logic signed [P_W-1:0]   shifted;
  logic signed [P_W-1:0]   term;
  logic signed [P_W-1:0]   sum;
  logic signed [P_W-1:0]   prod_nxt;
  logic                    last_dig;

  booth_pp_gen #(.A_W(A_W)) u_pp_gen (
    .a       (a_r),
    .m3      (m3_r),
    .sel     (dig_sel),
    .pp_mag  (pp_mag),
    .pp_neg  (pp_neg),
    .illegal (pp_ill)
  );

  // Magnitude is non-negative; the sign comes from the digit, applied after the shift.
  assign mag_ext  = {{(P_W-MAG_W){pp_mag[MAG_W-1]}}, pp_mag};
  assign shifted  = mag_ext <<< (3 * int'(idx));
  assign term     = pp_neg ? -shifted : shifted;
  assign sum      = acc + term;
  assign last_dig = (idx == IDX_W'(NDIG-1));

`ifdef BOOTH_ACC_SAT_EN
  logic         sat_r;
  logic [P_W:0] clamp_res;

  function automatic logic [P_W:0] clamp_pix(input logic signed [P_W-1:0] v);
    logic signed [P_W-1:0] pix_max;
    pix_max = P_W'((1 << A_W) - 1);
    if (v < 0)             return {1'b1, {P_W{1'b0}}};
    else if (v > pix_max)  return {1'b1, pix_max};
    return {1'b0, v};
  endfunction

  assign clamp_res = clamp_pix(sum);
  assign prod_nxt  = clamp_res[P_W-1:0];
  assign prod_sat  = sat_r;
`else
  assign prod_nxt  = sum;
  assign prod_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    dig_ready   = 1'b0;
    prod_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = PRE;
      end
      PRE:  state_nxt = ACC;
      ACC: begin
        dig_ready = 1'b1;
        if (dig_valid && last_dig) state_nxt = DONE;
      end
      DONE: begin
        prod_valid = 1'b1;
        if (prod_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      m3_r     <= '0;
      acc      <= '0;
      idx      <= '0;
      err_r    <= 1'b0;
      prod     <= '0;
      prod_err <= 1'b0;
`ifdef BOOTH_ACC_SAT_EN
      sat_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_r   <= a_in;
          acc   <= '0;
          idx   <= '0;
          err_r <= 1'b0;
        end
        // 3a is the only multiple that is not a shift; precompute it once per product
        PRE: m3_r <= {2'b00, a_r} + {1'b0, a_r, 1'b0};
        ACC: if (dig_valid) begin
          acc   <= sum;
          idx   <= idx + 1'b1;
          err_r <= err_r | pp_ill;
          if (last_dig) begin
            prod     <= prod_nxt;
            prod_err <= err_r | pp_ill;
`ifdef BOOTH_ACC_SAT_EN
            sat_r    <= clamp_res[P_W];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Scoreboard bench for booth_pp_accum (A_W=8, NDIG=3): directed digit vectors with
// hand-computed products; honours BOOTH_ACC_SAT_EN for the clamped expectations.
module tb_booth_pp_accum;

`ifdef BOOTH_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_valid = 1'b0;
  logic               start_ready;
  logic [7:0]         a_in = '0;
  logic               dig_valid = 1'b0;
  logic               dig_ready;
  logic [3:0]         dig_sel = '0;
  logic               prod_valid;
  logic               prod_ready = 1'b1;
  logic signed [17:0] prod;
  logic               prod_err;
  logic               prod_sat;

  typedef struct {
    logic signed [17:0] p;
    logic               e;
    logic               s;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  booth_pp_accum #(.A_W(8), .NDIG(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .dig_valid   (dig_valid),
    .dig_ready   (dig_ready),
    .dig_sel     (dig_sel),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod        (prod),
    .prod_err    (prod_err),
    .prod_sat    (prod_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, bit ok, longint act, longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: compares every accepted product against the oldest expectation.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && prod_valid && prod_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_prod", 1'b0, longint'(prod), 0);
      end else begin
        m_e = sb_q.pop_front();
        chk("prod",     prod == m_e.p,     longint'(prod),     longint'(m_e.p));
        chk("prod_err", prod_err == m_e.e, longint'(prod_err), longint'(m_e.e));
        chk("prod_sat", prod_sat == m_e.s, longint'(prod_sat), longint'(m_e.s));
      end
    end
  end

  task automatic start_hs(input logic [7:0] a, output int hs_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("start_ready_timeout", 1'b0, 0, 1);
    start_valid = 1'b1;
    a_in        = a;
    hs_cyc      = cyc;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in        = 8'hA5;
  endtask

  task automatic send_digit(input logic [3:0] d, input int gap);
    bit ok = 1'b0;
    bit rdy;
    if (gap > 0) begin
      dig_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    dig_valid = 1'b1;
    dig_sel   = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rdy = dig_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("dig_ready_timeout", 1'b0, 0, 1);
  endtask

  task automatic run_prod(input logic [7:0] a, input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input int gap, input int hold,
                          input logic signed [17:0] raw, input logic err,
                          input logic signed [17:0] sat_val, input logic sat_flag);
    exp_t e;
    int   hs_cyc;
    bit   ok = 1'b0;
    e.p = SAT_EN ? sat_val : raw;
    e.e = err;
    e.s = SAT_EN ? sat_flag : 1'b0;
    sb_q.push_back(e);
    prod_ready = (hold == 0);
    start_hs(a, hs_cyc);
    send_digit(d0, gap);
    send_digit(d1, gap);
    send_digit(d2, gap);
    dig_valid = 1'b0;
    dig_sel   = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prod_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("prod_valid_timeout", 1'b0, 0, 1);
    else if (gap == 0) chk("latency", (cyc - hs_cyc) == 5, cyc - hs_cyc, 5);
    for (int i = 0; i < hold; i++) begin
      chk("hold_prod", prod == e.p && prod_valid, longint'(prod), longint'(e.p));
      chk("hold_start_ready", start_ready == 1'b0, longint'(start_ready), 0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      prod_ready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!prod_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("prod_valid_drop_timeout", 1'b0, 1, 0);
    else chk("prod_kept", prod == e.p, longint'(prod), longint'(e.p));
    @(posedge clk); #1;
  endtask

  initial begin
    int hs_cyc;
    #2;
    chk("rst_prod",        prod == 0,           longint'(prod),        0);
    chk("rst_prod_valid",  prod_valid == 1'b0,  longint'(prod_valid),  0);
    chk("rst_prod_err",    prod_err == 1'b0,    longint'(prod_err),    0);
    chk("rst_prod_sat",    prod_sat == 1'b0,    longint'(prod_sat),    0);
    chk("rst_start_ready", start_ready == 1'b1, longint'(start_ready), 1);
    chk("rst_dig_ready",   dig_ready == 1'b0,   longint'(dig_ready),   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //        a    d0     d1     d2    gap hold  raw     err  sat_val sat
    run_prod(200, 4'h1, 4'h0, 4'h0, 0, 0,     200, 1'b0,     200, 1'b0);
    run_prod(200, 4'h9, 4'h1, 4'h0, 0, 0,    1400, 1'b0,     255, 1'b1);
    run_prod(255, 4'hC, 4'hC, 4'hC, 0, 0,  -74460, 1'b0,       0, 1'b1);
    run_prod(255, 4'h4, 4'h4, 4'h4, 0, 0,   74460, 1'b0,     255, 1'b1);
    run_prod(255, 4'hB, 4'h0, 4'h0, 0, 0,    -765, 1'b0,       0, 1'b1);
    run_prod( 10, 4'h7, 4'h1, 4'h0, 0, 0,      80, 1'b1,      80, 1'b0);
    run_prod( 10, 4'h7, 4'h1, 4'h0, 3, 0,      80, 1'b1,      80, 1'b0);
    run_prod(  3, 4'h3, 4'h3, 4'h0, 0, 0,      81, 1'b0,      81, 1'b0);
    run_prod(  5, 4'h8, 4'h1, 4'h1, 0, 0,     360, 1'b1,     255, 1'b1);
    run_prod(100, 4'h2, 4'h2, 4'h0, 0, 5,    1800, 1'b0,     255, 1'b1);

    // Abort a product mid-accumulation with reset.
    start_hs(8'd200, hs_cyc);
    send_digit(4'h1, 0);
    dig_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("abort_prod",        prod == 0,           longint'(prod),        0);
    chk("abort_prod_valid",  prod_valid == 1'b0,  longint'(prod_valid),  0);
    chk("abort_prod_err",    prod_err == 1'b0,    longint'(prod_err),    0);
    chk("abort_prod_sat",    prod_sat == 1'b0,    longint'(prod_sat),    0);
    chk("abort_dig_ready",   dig_ready == 1'b0,   longint'(dig_ready),   0);
    chk("abort_start_ready", start_ready == 1'b1, longint'(start_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_prod(200, 4'h1, 4'h0, 4'h0, 0, 0,     200, 1'b0,     200, 1'b0);

    chk("scoreboard_empty", sb_q.size() == 0, sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
